// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready slave with wait states and word RAM.
// Optional status mailbox (done/pass) enabled by DMEM_STATUS_MAILBOX_EN.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int STATUS_ADDR = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        done,
  output logic        pass
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic        acc;
  logic        acc_we;
  logic        acc_in;
  logic [29:0] acc_idx;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [31:0] mem_rd;
  logic        unused_addr;

  logic [31:0] mem [DEPTH];

  assign unused_addr = ^req_addr[1:0];

  // In IDLE the access (zero wait states) uses the live request.
  always_comb begin
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_idx   = req_addr[31:2];
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_in = ({2'b00, acc_idx} < 32'(DEPTH));
  assign mem_rd = mem[acc_idx[AW-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = done_q;
    pass_d  = pass_q;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[31:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            acc     = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          acc     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc) begin
      err_d   = !acc_in;
      rdata_d = (acc_in && !acc_we) ? mem_rd : 32'd0;
`ifdef DMEM_STATUS_MAILBOX_EN
      if (acc_we && acc_idx == 30'(STATUS_ADDR >> 2)) begin
        done_d = 1'b1;
        pass_d = (acc_wdata == 32'd25);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // RAM is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && acc && acc_we && acc_in) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i])
          mem[acc_idx[AW-1:0]][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with hand-computed expectations.
// Mailbox expectations follow DMEM_STATUS_MAILBOX_EN.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        done;
  logic        pass;

  int n_chk = 0;
  int n_err = 0;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .done      (done),
    .pass      (pass)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One full transaction; hold>0 keeps rsp_ready low that many cycles.
  task automatic txn(input logic we,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [3:0] be,
                     input int hold,
                     output logic [31:0] rd,
                     output logic er,
                     output int lat);
    int g;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = 32'hDEAD_BEEF;
    req_be    = ~be;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, rd);
      check("bp_err", 32'(rsp_err), 32'(er));
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        exp_done;
  logic        exp_pass;

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;

    #15;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    #7;
    reset = 1'b0;

    // store then load back, full word
    txn(1'b1, 32'd8, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    check("st8_lat", 32'(lat), 32'd3);
    check("st8_rdata", rd, 32'd0);
    check("st8_err", 32'(er), 32'd0);
    txn(1'b0, 32'd8, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld8_lat", 32'(lat), 32'd3);
    check("ld8_rdata", rd, 32'h1234_5678);
    check("ld8_err", 32'(er), 32'd0);

    // partial byte-lane store
    txn(1'b1, 32'd12, 32'h1122_3344, 4'hF, 0, rd, er, lat);
    txn(1'b1, 32'd12, 32'hAABB_CCDD, 4'h3, 0, rd, er, lat);
    txn(1'b0, 32'd12, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld12_be3", rd, 32'h1122_CCDD);
    txn(1'b1, 32'd15, 32'h99EE_0000, 4'hC, 0, rd, er, lat);
    txn(1'b0, 32'd13, 32'h0, 4'hF, 0, rd, er, lat);
    check("ld12_beC_lowbits", rd, 32'h99EE_CCDD);

    // backpressure
    txn(1'b0, 32'd8, 32'h0, 4'h0, 5, rd, er, lat);
    check("bp_ld8_rdata", rd, 32'h1234_5678);
    check("bp_ld8_lat", 32'(lat), 32'd3);

    // store with no enabled lanes
    txn(1'b1, 32'd8, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
    txn(1'b0, 32'd8, 32'h0, 4'h0, 0, rd, er, lat);
    check("be0_nochange", rd, 32'h1234_5678);

    // range boundaries
    txn(1'b1, 32'd0, 32'h5A5A_5A5A, 4'hF, 0, rd, er, lat);
    txn(1'b1, 32'd252, 32'hC0DE_0252, 4'hF, 0, rd, er, lat);
    check("st252_err", 32'(er), 32'd0);
    txn(1'b0, 32'd256, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld256_err", 32'(er), 32'd1);
    check("ld256_rdata", rd, 32'd0);
    txn(1'b1, 32'd256, 32'hBAD0_BAD0, 4'hF, 0, rd, er, lat);
    check("st256_err", 32'(er), 32'd1);
    check("st256_rdata", rd, 32'd0);
    txn(1'b0, 32'd0, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld0_rdata", rd, 32'h5A5A_5A5A);
    check("ld0_err", 32'(er), 32'd0);
    txn(1'b0, 32'd252, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld252_rdata", rd, 32'hC0DE_0252);

    // reset while a store waits
    txn(1'b1, 32'd16, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    txn(1'b0, 32'd8, 32'h0, 4'h0, 0, rd, er, lat);
    @(negedge clk);
    req_we    = 1'b1;
    req_addr  = 32'd16;
    req_wdata = 32'h0BAD_BEEF;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("wait_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    check("mid_rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(1'b0, 32'd16, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld16_after_rst", rd, 32'hCAFE_F00D);

    // status mailbox
`ifdef DMEM_STATUS_MAILBOX_EN
    exp_done = 1'b1;
    exp_pass = 1'b1;
`else
    exp_done = 1'b0;
    exp_pass = 1'b0;
`endif
    txn(1'b1, 32'd100, 32'd25, 4'hF, 0, rd, er, lat);
    check("mb25_done", 32'(done), 32'(exp_done));
    check("mb25_pass", 32'(pass), 32'(exp_pass));
    exp_pass = 1'b0;
    txn(1'b1, 32'd100, 32'd7, 4'hF, 0, rd, er, lat);
    check("mb7_done", 32'(done), 32'(exp_done));
    check("mb7_pass", 32'(pass), 32'(exp_pass));
    txn(1'b0, 32'd100, 32'h0, 4'h0, 0, rd, er, lat);
    check("mb_ram", rd, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
